zmc_sync: RTL

//  Clocked Z80 memory controller for the cartridge board: sits between the Z80 address bus
//  (SDA) and the M1 ROM address pins, downstream of the sound CPU, upstream of rom_m1.

---
 rtl/zmc_sync_pkg.sv | 46 ++++
 rtl/zmc_sync_if.sv | 11 +
 rtl/zmc_sync_rise.sv | 41 ++++
 rtl/zmc_sync.sv | 91 +++++++++
 4 files changed

// File: rtl/zmc_sync_pkg.sv
// Shared definitions for the Z80 memory controller: window bases, register
// select codes, window classification and reset-time bank defaults.
package zmc_sync_pkg;

  // Z80 address window base addresses
  localparam logic [15:0] WIN_16K_BASE = 16'h8000;
  localparam logic [15:0] WIN_8K_BASE  = 16'hC000;
  localparam logic [15:0] WIN_4K_BASE  = 16'hE000;
  localparam logic [15:0] WIN_2K_BASE  = 16'hF000;
  localparam logic [15:0] WRAM_BASE    = 16'hF800;

  // Bank register select codes carried on SDA[1:0]
  localparam logic [1:0] SEL_2K  = 2'd0;
  localparam logic [1:0] SEL_4K  = 2'd1;
  localparam logic [1:0] SEL_8K  = 2'd2;
  localparam logic [1:0] SEL_16K = 2'd3;

  // Default banks give a flat map of the upper 32K after reset
  localparam logic [7:0] DEF_BANK_2K  = 8'h1E;
  localparam logic [7:0] DEF_BANK_4K  = 8'h0E;
  localparam logic [7:0] DEF_BANK_8K  = 8'h06;
  localparam logic [7:0] DEF_BANK_16K = 8'h02;

  typedef enum logic [2:0] {
    WIN_FLAT = 3'd0,
    WIN_16K  = 3'd1,
    WIN_8K   = 3'd2,
    WIN_4K   = 3'd3,
    WIN_2K   = 3'd4
  } win_e;

  // Classify an address by its 2K page number SDA[15:11]
  function automatic win_e decode_window(input logic [4:0] page);
    win_e w;
    casez (page)
      5'b0????: w = WIN_FLAT;   // 0000-7FFF fixed ROM
      5'b10???: w = WIN_16K;    // 8000-BFFF
      5'b110??: w = WIN_8K;     // C000-DFFF
      5'b1110?: w = WIN_4K;     // E000-EFFF
      5'b11110: w = WIN_2K;     // F000-F7FF
      default:  w = WIN_FLAT;   // F800-FFFF work RAM
    endcase
    return w;
  endfunction

endpackage

// File: rtl/zmc_sync_if.sv
// Z80-side bus bundle of the memory controller: bank-write strobe and
// address in, M1 ROM upper address and write pulse out.
interface zmc_sync_if;
  logic        SDRD0;
  logic [15:0] SDA;
  logic [10:0] MA;
  logic        BANK_WR;

  modport master (output SDRD0, output SDA, input MA, input BANK_WR);
  modport slave  (input SDRD0, input SDA, output MA, output BANK_WR);
endinterface

// File: rtl/zmc_sync_rise.sv
// N-stage synchroniser with configurable reset value. Emits a registered
// per-bit rise pulse and a copy of the last stage aligned with that pulse,
// so a data pipeline built from the same module lines up with the strobe.
module sync_rise_detect #(
  parameter int                 WIDTH   = 1,
  parameter int                 STAGES  = 2,
  parameter logic [WIDTH-1:0]   RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stage_r [STAGES];
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] rise_r;

  // Shift input through the stages, remember last stage, flag 0->1 on it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= RST_VAL;
      end
      prev_r <= RST_VAL;
      rise_r <= {WIDTH{1'b0}};
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
      prev_r <= stage_r[STAGES-1];
      rise_r <= stage_r[STAGES-1] & ~prev_r;
    end
  end

  assign q    = prev_r;
  assign rise = rise_r;

endmodule

// File: rtl/zmc_sync.sv
// Z80 memory controller: latches four bank registers from synchronised
// SDRD0 strobes and maps the Z80 address onto M1 ROM address bits [21:11].
module zmc_sync
  import zmc_sync_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] RST_BANK_2K  = DEF_BANK_2K,
  parameter logic [7:0] RST_BANK_4K  = DEF_BANK_4K,
  parameter logic [7:0] RST_BANK_8K  = DEF_BANK_8K,
  parameter logic [7:0] RST_BANK_16K = DEF_BANK_16K
) (
  input  logic       CLK_24M,
  input  logic       nRESET,
  zmc_sync_if.slave  bus
);

  logic        strobe_rise_s;
  logic        strobe_sync_unused_s;
  logic [9:0]  wr_data_s;          // {bank value, register select}
  logic [9:0]  wr_rise_unused_s;
  win_e        win_s;
  logic [10:0] ma_next_s;

  logic [7:0]  bank_r [4];
  logic [10:0] ma_r;
  logic        bank_wr_r;

  // Strobe synchroniser resets high so a strobe held through reset is ignored
  sync_rise_detect #(
    .WIDTH   (1),
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_strobe (
    .clk   (CLK_24M),
    .rst_n (nRESET),
    .d     (bus.SDRD0),
    .q     (strobe_sync_unused_s),
    .rise  (strobe_rise_s)
  );

  // Only the bank value and select bits travel alongside the strobe
  sync_rise_detect #(
    .WIDTH   (10),
    .STAGES  (SYNC_STAGES),
    .RST_VAL ({10{1'b0}})
  ) u_wr_data (
    .clk   (CLK_24M),
    .rst_n (nRESET),
    .d     ({bus.SDA[15:8], bus.SDA[1:0]}),
    .q     (wr_data_s),
    .rise  (wr_rise_unused_s)
  );

  assign win_s = decode_window(bus.SDA[15:11]);

  // Translate the live Z80 address through the current bank registers
  always_comb begin
    ma_next_s = {7'b0000000, bus.SDA[14:11]};
    case (win_s)
      WIN_16K:  ma_next_s = {bank_r[SEL_16K], bus.SDA[13:11]};
      WIN_8K:   ma_next_s = {1'b0, bank_r[SEL_8K], bus.SDA[12:11]};
      WIN_4K:   ma_next_s = {2'b00, bank_r[SEL_4K], bus.SDA[11]};
      WIN_2K:   ma_next_s = {3'b000, bank_r[SEL_2K]};
      WIN_FLAT: ma_next_s = {7'b0000000, bus.SDA[14:11]};
      default:  ma_next_s = {7'b0000000, bus.SDA[14:11]};
    endcase
  end

  // Register MA, update the selected bank and pulse BANK_WR on a strobe rise;
  // MA is computed from the pre-write bank, so a new bank shows one cycle later
  always_ff @(posedge CLK_24M) begin
    if (!nRESET) begin
      bank_r[SEL_2K]  <= RST_BANK_2K;
      bank_r[SEL_4K]  <= RST_BANK_4K;
      bank_r[SEL_8K]  <= RST_BANK_8K;
      bank_r[SEL_16K] <= RST_BANK_16K;
      ma_r            <= 11'h000;
      bank_wr_r       <= 1'b0;
    end else begin
      ma_r      <= ma_next_s;
      bank_wr_r <= strobe_rise_s;
      if (strobe_rise_s) begin
        bank_r[wr_data_s[1:0]] <= wr_data_s[9:2];
      end
    end
  end

  assign bus.MA      = ma_r;
  assign bus.BANK_WR = bank_wr_r;

endmodule
